// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_end = !clear && (count == LAST);

    // Wrapping on bit_end keeps chained bits and frames gap-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter: pops one FIFO entry per frame and chains frames with no idle gap.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLK_FREQ     = 27000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next, shifted;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic                  tx_next, read_en_next, busy_next, byte_done_next;
    logic                  bit_end, baud_clear, can_start;

    assign baud_clear = (state == IDLE);
    assign can_start  = tx_enable && !fifo_empty;
    assign shifted    = shift_reg >> 1;

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // Every output is computed one cycle ahead so the registers below drive the pins.
    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt;
        tx_next        = tx;
        read_en_next   = 1'b0;
        byte_done_next = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (can_start) begin
                    shift_next   = fifo_data;
                    read_en_next = 1'b1;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next      = shift_reg[0];
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        tx_next      = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        shift_next   = shifted;
                        tx_next      = shifted[0];
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    byte_done_next = 1'b1;
                    if (can_start) begin
                        shift_next   = fifo_data;
                        read_en_next = 1'b1;
                        tx_next      = 1'b0;
                        state_next   = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            tx           <= 1'b1;
            fifo_read_en <= 1'b0;
            busy         <= 1'b0;
            byte_done    <= 1'b0;
        end else begin
            state        <= state_next;
            shift_reg    <= shift_next;
            bit_cnt      <= bit_cnt_next;
            tx           <= tx_next;
            fifo_read_en <= read_en_next;
            busy         <= busy_next;
            byte_done    <= byte_done_next;
        end
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains bytes from the board's byte FIFO and serialises each one as an 8N1 UART frame on the TX pin. It is the read-side consumer of the FIFO. It pops one entry per frame, using the FIFO's combinational `data_out`/`empty` and its `read_en` pop strobe. Frames go back-to-back while data is available and `tx_enable` is high.

## Interface
- `DATA_WIDTH`, default 8: bits per frame payload; must match the FIFO width.
- `CLK_FREQ`, default 27000000: `clk` frequency in Hz.
- `BAUD`, default 115200: line rate.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (integer division, 234 at defaults): cycles per bit. Must be ≥ 2.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `tx_enable`, in, 1: permits starting a new frame. It is not sampled mid-frame.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_data`, in, DATA_WIDTH: FIFO head entry. Combinational and valid whenever `fifo_empty`=0.
- `fifo_read_en`, out, 1: one-cycle pop strobe to the FIFO. Registered.
- `tx`, out, 1: serial line, idle high. Registered.
- `busy`, out, 1: high while a frame is in progress (state ≠ IDLE).
- `byte_done`, out, 1: one-cycle pulse when a frame's stop bit completes.

## Operation
- The states are IDLE, START, DATA and STOP. All outputs are registered.
- **Reset values:** `tx`=1, `fifo_read_en`=0, `busy`=0, `byte_done`=0. Internally, state=IDLE and both counters are 0.
- **IDLE:** on an edge where `tx_enable`=1 and `fifo_empty`=0:
  - latch `fifo_data` into the shift register;
  - assert `fifo_read_en` for exactly the next cycle;
  - go to START.
- **Counters:**
  - The baud counter runs 0..CLKS_PER_BIT-1.
  - A bit ends when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - The bit counter is `$clog2(DATA_WIDTH)` bits wide and runs 0..DATA_WIDTH-1.
- **START:** `tx`=0 for one bit time, then go to DATA.
- **DATA:** `tx`=shift_reg[0], LSB first. At each bit end, shift right. After bit DATA_WIDTH-1, go to STOP.
- **STOP:** `tx`=1 for one bit time. At the stop-bit end:
  - pulse `byte_done` for one cycle;
  - if `tx_enable`=1 and `fifo_empty`=0, do the IDLE capture/pop directly and go to START (no idle gap);
  - otherwise go to IDLE.
- **At most one pop per frame.**
  - `fifo_empty` is sampled only in IDLE or at the stop-bit end.
  - The FIFO's registered count has settled long before the next sample.
- **`tx_enable` falling mid-frame:** the current frame completes unchanged. No further frame starts.
- **FIFO empty:** no pop and no frame. `tx` stays 1 and `busy` stays 0.
- **`reset_n` asserted mid-frame:**
  - All outputs take their reset values immediately (`tx`=1, line released).
  - The partially sent byte is lost.
  - No pop is issued.

## Timing
- **Start latency:** capture edge E. Then `fifo_read_en`=1, `busy`=1 and `tx`=0 all during cycle E+1.
- **Pop:** the FIFO pops at edge E+1.
- **Frame length:** exactly `(DATA_WIDTH+2)*CLKS_PER_BIT` cycles of `tx`, i.e. 10×234=2340 at defaults.
- **Back-to-back frames:** the period equals the frame length, with zero extra idle cycles.
- **`byte_done`:** high during the first cycle after the stop bit, coincident with `tx`=0 of the next start bit if chained.
- **`busy`:** falls in that same cycle when not chained.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, DATA, STOP};
  - helper function `clks_per_bit(CLK_FREQ, BAUD)`.
  - The future `uart_rx` shares this package.
- Sub-module `baud_counter`:
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `reset_n`, `clear`;
  - output `bit_end` pulse.
  - It is held clear in IDLE.

## Test plan
Unless stated otherwise, the bench uses CLK_FREQ=1000000 and BAUD=250000, giving CLKS_PER_BIT=4.

- **Single byte:** FIFO holds 0x48, `tx_enable`=1. Expect:
  - one `fifo_read_en` pulse;
  - `tx` sequence, 4 cycles per bit: 0,0,0,0,1,0,0,1,0,1;
  - `byte_done` at cycle 41 after capture;
  - then `busy`=0.
- **Back-to-back:** FIFO holds 0x55, 0xAA, 0x00. Expect:
  - three frames at an exact 40-cycle period;
  - exactly 3 pops;
  - FIFO empty afterwards.
- **Empty / disabled:**
  - With the FIFO empty for 200 cycles: `tx`=1, no pop, `busy`=0.
  - With the FIFO non-empty but `tx_enable`=0: same result.
- **Enable drop mid-frame:** drop `tx_enable` during bit 3 of 0x41 with 0x42 queued. Expect:
  - 0x41 completes;
  - 0x42 is not popped;
  - re-enabling sends 0x42.
- **Reset mid-frame:** pulse `reset_n` low during DATA. Expect:
  - `tx`=1, `busy`=0 and `fifo_read_en`=0 asynchronously;
  - after release, the next queued byte is framed correctly.
- **Defaults sweep:** at 27 MHz / 115200, the bit period is 234 cycles and the frame is 2340 cycles. A bench UART receiver decodes "Hello" without error.
